// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline register file: size defaults, the
// register-address type, the x0 constant and an address range helper.
package pipe_pkg;

    localparam int XLEN_DEF = 64;
    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = 5;

    typedef logic [AW_DEF-1:0] reg_addr_t;

    localparam reg_addr_t X0 = '0;

    // True when the address names an implemented register (x0 included).
    function automatic logic addr_in_range(input reg_addr_t addr, input int nreg);
        return int'(addr) < nreg;
    endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Load-use scoreboard: tracks registers awaiting a load writeback and
// raises stall when a read port needs one that the bypass cannot supply.
module pipe_scoreboard
    import pipe_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int NRD  = 2,
    parameter int AW   = AW_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic              wr_ok,
    input  logic [AW-1:0]     wr_addr,
    input  logic              iss_valid,
    input  logic              iss_load,
    input  logic [AW-1:0]     iss_rd,
    output logic              stall,
    output logic [NREG-1:0]   busy_vec
);

    logic [NRD-1:0]  port_stall;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    for (genvar k = 0; k < NRD; k++) begin : g_port
        logic [AW-1:0] addr;
        assign addr = rd_addr[k*AW +: AW];
        assign port_stall[k] = addr_in_range(addr, NREG) && busy_vec[addr]
                               && !(wr_ok && (addr == wr_addr));
    end

    assign stall = |port_stall;

    // Sets are suppressed while stalled so a held decode cannot mark a register twice.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (wr_ok) begin
            clr_mask[wr_addr] = 1'b1;
        end
        if (iss_valid && iss_load && !stall && (iss_rd != AW'(X0))
            && addr_in_range(iss_rd, NREG)) begin
            set_mask[iss_rd] = 1'b1;
        end
    end

    // Clear first, then set, so a new load to the register being written back wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= (busy_vec & ~clr_mask) | set_mask;
        end
    end

endmodule

// File: rtl/pipe_regfile.sv
// Multi-read-port register file with write-through bypass, load-use
// scoreboard and sticky out-of-range flag. PIPE_REGFILE_INIT_EN: reset loads xi=i.
module pipe_regfile
    import pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = 2,
    parameter int AW   = AW_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_valid,
    input  logic                iss_load,
    input  logic [AW-1:0]       iss_rd,
    output logic                stall,
    output logic [NREG-1:0]     busy_vec,
    output logic                err_addr
);

    logic [XLEN-1:0] regs [NREG];
    logic            wr_ok;
    logic [NRD-1:0]  rd_oob;
    logic            any_oob;

    assign wr_ok = wr_en && (wr_addr != AW'(X0)) && addr_in_range(wr_addr, NREG);

    for (genvar k = 0; k < NRD; k++) begin : g_read
        logic [AW-1:0] addr;
        assign addr = rd_addr[k*AW +: AW];
        assign rd_oob[k] = !addr_in_range(addr, NREG);
        assign rd_data[k*XLEN +: XLEN] =
            (rd_oob[k] || (addr == AW'(X0))) ? '0 :
            (wr_ok && (addr == wr_addr))     ? wr_data :
                                               regs[addr];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
`ifdef PIPE_REGFILE_INIT_EN
                regs[i] <= XLEN'(i);
`else
                regs[i] <= '0;
`endif
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign any_oob = (|rd_oob)
                     || (wr_en && !addr_in_range(wr_addr, NREG))
                     || (iss_valid && !addr_in_range(iss_rd, NREG));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_addr <= 1'b0;
        end else if (any_oob) begin
            err_addr <= 1'b1;
        end
    end

    pipe_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD),
        .AW   (AW)
    ) u_scoreboard (
        .clock     (clock),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .wr_ok     (wr_ok),
        .wr_addr   (wr_addr),
        .iss_valid (iss_valid),
        .iss_load  (iss_load),
        .iss_rd    (iss_rd),
        .stall     (stall),
        .busy_vec  (busy_vec)
    );

endmodule
